// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Constants for the 8x16 register file. The operand-select and writeback
// stages use the same constants.
//   RF_WIDTH    : register data width
//   RF_ADDR_W   : register index width
//   RF_NUM_REGS : number of architectural registers
//   rf_onehot() : index to one-hot decode, used for the write and reserve decode
// ----------------------------------------------------------------------------
package rf_pkg;

   localparam int RF_WIDTH    = 16;
   localparam int RF_ADDR_W   = 3;
   localparam int RF_NUM_REGS = 8;

   function automatic logic [RF_NUM_REGS-1:0] rf_onehot(input logic [RF_ADDR_W-1:0] sel);
      return RF_NUM_REGS'(1) << sel;
   endfunction

endpackage

// File: rtl/reg_file_8x16_if.sv
// ----------------------------------------------------------------------------
// reg_file_8x16_if
// Interface for the register file: two read ports, the writeback port and
// the issue/reserve handshake.
//   RA_SEL/RB_SEL     : read indices              (master -> slave)
//   RA_DATA/RB_DATA   : read data                 (slave -> master)
//   RA_READY/RB_READY : selected register free    (slave -> master)
//   WR_EN/WR_SEL/WR_DATA : writeback              (master -> slave)
//   ISSUE_EN/ISSUE_SEL   : reserve request        (master -> slave)
//   ISSUE_ACK            : reservation accepted   (slave -> master)
// Modports: master (issue/writeback side), slave (register file).
// ----------------------------------------------------------------------------
interface reg_file_8x16_if
   import rf_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH
);
   logic [RF_ADDR_W-1:0] RA_SEL;
   logic [RF_ADDR_W-1:0] RB_SEL;
   logic [WIDTH-1:0]     RA_DATA;
   logic [WIDTH-1:0]     RB_DATA;
   logic                 RA_READY;
   logic                 RB_READY;
   logic                 WR_EN;
   logic [RF_ADDR_W-1:0] WR_SEL;
   logic [WIDTH-1:0]     WR_DATA;
   logic                 ISSUE_EN;
   logic [RF_ADDR_W-1:0] ISSUE_SEL;
   logic                 ISSUE_ACK;

   modport master (
      output RA_SEL, RB_SEL, WR_EN, WR_SEL, WR_DATA, ISSUE_EN, ISSUE_SEL,
      input  RA_DATA, RB_DATA, RA_READY, RB_READY, ISSUE_ACK
   );

   modport slave (
      input  RA_SEL, RB_SEL, WR_EN, WR_SEL, WR_DATA, ISSUE_EN, ISSUE_SEL,
      output RA_DATA, RB_DATA, RA_READY, RB_READY, ISSUE_ACK
   );
endinterface

// File: rtl/rf_read_port.sv
// ----------------------------------------------------------------------------
// rf_read_port
// One combinational read port. An 8:1 mux (MUX_16_8) uses S0..S2 = i_sel[0..2]
// and selects the register value. The port also selects the ready flag from
// the pending vector. When RF_BYPASS_EN is defined, a same-cycle write to the
// selected register is forwarded to the output. When RF_BYPASS_EN is not
// defined, the writeback inputs are not used.
//   i_regs    : register contents
//   i_pend    : per-register pending flags
//   i_sel     : register index
//   i_wr_*    : writeback port (used only for the bypass)
//   o_data    : read data
//   o_ready   : selected register is not pending
// ----------------------------------------------------------------------------
module rf_read_port
   import rf_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic [WIDTH-1:0]       i_regs [RF_NUM_REGS],
   input  logic [RF_NUM_REGS-1:0] i_pend,
   input  logic [RF_ADDR_W-1:0]   i_sel,
   input  logic                   i_wr_en,
   input  logic [RF_ADDR_W-1:0]   i_wr_sel,
   input  logic [WIDTH-1:0]       i_wr_data,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_ready
);
   // Binary mux tree: S0 picks within pairs, S1 within quads, S2 picks the half.
   logic [WIDTH-1:0] w_lvl1 [4];
   logic [WIDTH-1:0] w_lvl2 [2];
   logic [WIDTH-1:0] w_mux;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lvl1
         assign w_lvl1[gi] = i_sel[0] ? i_regs[2*gi+1] : i_regs[2*gi];
      end
      for (genvar gi = 0; gi < 2; gi++) begin : g_lvl2
         assign w_lvl2[gi] = i_sel[1] ? w_lvl1[2*gi+1] : w_lvl1[2*gi];
      end
   endgenerate

   assign w_mux = i_sel[2] ? w_lvl2[1] : w_lvl2[0];

   logic w_is_zero;
   logic w_hit;
   assign w_is_zero = ZERO_REG && (i_sel == '0);

`ifdef RF_BYPASS_EN
   assign w_hit = i_wr_en && (i_wr_sel == i_sel) && !w_is_zero;
`else
   assign w_hit = 1'b0;
   logic w_unused_wr;
   assign w_unused_wr = &{1'b0, i_wr_en, i_wr_sel, i_wr_data};
`endif

   always_comb begin
      o_data  = w_mux;
      o_ready = ~i_pend[i_sel];
      if (w_hit) begin
         o_data  = i_wr_data;
         o_ready = 1'b1;
      end
      if (w_is_zero) begin
         o_data  = '0;
         o_ready = 1'b1;
      end
   end
endmodule

// File: rtl/reg_file_8x16.sv
// ----------------------------------------------------------------------------
// reg_file_8x16
// This module is an 8-entry general-purpose register file. It has two
// combinational read ports, one synchronous writeback port and a pending
// scoreboard. Each register has one pending flag. Issue logic sets the flag
// to reserve a register. A writeback to that register clears the flag.
//   CLK : rising-edge clock
//   RST : synchronous, active-high reset. It clears all registers and all
//         pending flags.
//   bus : reg_file_8x16_if.slave. It carries the read ports, the writeback
//         port and the issue handshake.
// Parameters: WIDTH (data width), ZERO_REG (R0 is hard-wired to zero).
// Optional build macro: RF_BYPASS_EN. It forwards a same-cycle writeback to
// the read ports.
// ----------------------------------------------------------------------------
module reg_file_8x16
   import rf_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter bit ZERO_REG = 1'b1
) (
   input logic             CLK,
   input logic             RST,
   reg_file_8x16_if.slave  bus
);
   logic [WIDTH-1:0]       r_regs [RF_NUM_REGS];
   logic [RF_NUM_REGS-1:0] r_pend;

   logic                   w_wr_ok;
   logic                   w_ack;
   logic                   w_set_ok;
   logic [RF_NUM_REGS-1:0] w_wr_dec;
   logic [RF_NUM_REGS-1:0] w_set_dec;

   // With ZERO_REG set, R0 is never written and never reserved. An issue to
   // R0 still gets an ACK, because its pending flag is always 0.
   assign w_wr_ok  = bus.WR_EN && !(ZERO_REG && (bus.WR_SEL == '0));
   assign w_ack    = bus.ISSUE_EN &&
                     (!r_pend[bus.ISSUE_SEL] || (bus.WR_EN && (bus.WR_SEL == bus.ISSUE_SEL)));
   assign w_set_ok = w_ack && !(ZERO_REG && (bus.ISSUE_SEL == '0));

   assign w_wr_dec  = w_wr_ok  ? rf_onehot(bus.WR_SEL)    : '0;
   assign w_set_dec = w_set_ok ? rf_onehot(bus.ISSUE_SEL) : '0;

   assign bus.ISSUE_ACK = w_ack;

   // A reservation takes priority over a same-cycle writeback to the same
   // index. The new producer is still outstanding after the edge.
   generate
      for (genvar gi = 0; gi < RF_NUM_REGS; gi++) begin : g_reg
         always_ff @(posedge CLK) begin
            if (RST) begin
               r_regs[gi] <= '0;
            end else if (w_wr_dec[gi]) begin
               r_regs[gi] <= bus.WR_DATA;
            end
         end
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_wr_dec) | w_set_dec;
      end
   end

   rf_read_port #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) u_port_a (
      .i_regs    (r_regs),
      .i_pend    (r_pend),
      .i_sel     (bus.RA_SEL),
      .i_wr_en   (bus.WR_EN),
      .i_wr_sel  (bus.WR_SEL),
      .i_wr_data (bus.WR_DATA),
      .o_data    (bus.RA_DATA),
      .o_ready   (bus.RA_READY)
   );

   rf_read_port #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) u_port_b (
      .i_regs    (r_regs),
      .i_pend    (r_pend),
      .i_sel     (bus.RB_SEL),
      .i_wr_en   (bus.WR_EN),
      .i_wr_sel  (bus.WR_SEL),
      .i_wr_data (bus.WR_DATA),
      .o_data    (bus.RB_DATA),
      .o_ready   (bus.RB_READY)
   );
endmodule

// File: tb/tb_reg_file_8x16.sv
// ----------------------------------------------------------------------------
// tb_reg_file_8x16
// Self-checking bench for reg_file_8x16. Expected values go into a queue at
// the time the stimulus is driven. They are popped and compared when the
// outputs are sampled at the falling edge.
// ----------------------------------------------------------------------------
module tb_reg_file_8x16;
   import rf_pkg::*;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   reg_file_8x16_if #(.WIDTH(RF_WIDTH)) bus ();

   reg_file_8x16 #(.WIDTH(RF_WIDTH), .ZERO_REG(1'b1)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   string       tag_q[$];
   logic [31:0] exp_q[$];

   // Compares one observed value with its expected value and counts the check.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] exp);
      tag_q.push_back(tag);
      exp_q.push_back(exp);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      if (exp_q.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         chk(tag_q.pop_front(), obs, exp_q.pop_front());
      end
   endtask

   // Moves to just after the next rising edge. Inputs change here.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      bus.WR_EN    = 1'b0;
      bus.ISSUE_EN = 1'b0;
   endtask

   // Reference model used for the random phase.
   logic [15:0] m_regs [8];
   logic [7:0]  m_pend;

   initial begin
      RST = 1'b1;
      bus.RA_SEL = '0; bus.RB_SEL = '0;
      bus.WR_EN = 1'b1; bus.WR_SEL = 3'd3; bus.WR_DATA = 16'hFFFF;
      bus.ISSUE_EN = 1'b0; bus.ISSUE_SEL = '0;
      step();
      RST = 1'b0;
      idle();

      // Reset state. Every register reads 0 and is ready. There is no ACK.
      for (int i = 0; i < 8; i++) begin
         bus.RA_SEL = 3'(i); bus.RB_SEL = 3'(7 - i);
         sb_push($sformatf("rst_a_data_r%0d", i), 32'h0);
         sb_push($sformatf("rst_a_rdy_r%0d", i), 32'h1);
         sb_push($sformatf("rst_b_data_r%0d", 7 - i), 32'h0);
         #1;
         sb_pop(32'(bus.RA_DATA)); sb_pop(32'(bus.RA_READY));
         sb_pop(32'(bus.RB_DATA));
      end
      sb_push("rst_ack", 32'h0);
      @(negedge CLK); sb_pop(32'(bus.ISSUE_ACK));
      step();

      // Write, then read. In the write cycle the port shows the old value,
      // or the forwarded value when the bypass is built in.
      bus.WR_EN = 1'b1; bus.WR_SEL = 3'd5; bus.WR_DATA = 16'hA5C3; bus.RA_SEL = 3'd5;
      sb_push("wr_same_cycle", BYP ? 32'hA5C3 : 32'h0);
      @(negedge CLK); sb_pop(32'(bus.RA_DATA));
      step(); idle();
      sb_push("wr_next_cycle", 32'hA5C3);
      @(negedge CLK); sb_pop(32'(bus.RA_DATA));
      step();

      // Scoreboard: reserve R2, attempt a second reserve, then write back.
      bus.ISSUE_EN = 1'b1; bus.ISSUE_SEL = 3'd2; bus.RB_SEL = 3'd2;
      sb_push("iss_r2_ack", 32'h1);
      sb_push("iss_r2_rdy_before", 32'h1);
      @(negedge CLK); sb_pop(32'(bus.ISSUE_ACK)); sb_pop(32'(bus.RB_READY));
      step();
      sb_push("iss_r2_rdy_after", 32'h0);
      sb_push("iss_r2_second_ack", 32'h0);
      @(negedge CLK); sb_pop(32'(bus.RB_READY)); sb_pop(32'(bus.ISSUE_ACK));
      step(); idle();
      bus.WR_EN = 1'b1; bus.WR_SEL = 3'd2; bus.WR_DATA = 16'h0042;
      sb_push("wb_r2_rdy_same", BYP ? 32'h1 : 32'h0);
      sb_push("wb_r2_data_same", BYP ? 32'h0042 : 32'h0);
      @(negedge CLK); sb_pop(32'(bus.RB_READY)); sb_pop(32'(bus.RB_DATA));
      step(); idle();
      sb_push("wb_r2_rdy", 32'h1);
      sb_push("wb_r2_data", 32'h0042);
      @(negedge CLK); sb_pop(32'(bus.RB_READY)); sb_pop(32'(bus.RB_DATA));
      step();

      // Writeback and re-issue to R4 in the same cycle. The reservation wins.
      bus.ISSUE_EN = 1'b1; bus.ISSUE_SEL = 3'd4;
      sb_push("r4_first_ack", 32'h1);
      @(negedge CLK); sb_pop(32'(bus.ISSUE_ACK));
      step();
      bus.WR_EN = 1'b1; bus.WR_SEL = 3'd4; bus.WR_DATA = 16'h1234;
      sb_push("r4_simul_ack", 32'h1);
      @(negedge CLK); sb_pop(32'(bus.ISSUE_ACK));
      step(); idle();
      bus.RA_SEL = 3'd4;
      sb_push("r4_data", 32'h1234);
      sb_push("r4_rdy", 32'h0);
      @(negedge CLK); sb_pop(32'(bus.RA_DATA)); sb_pop(32'(bus.RA_READY));
      bus.ISSUE_EN = 1'b1; bus.ISSUE_SEL = 3'd4;
      sb_push("r4_still_pend_ack", 32'h0);
      #1; sb_pop(32'(bus.ISSUE_ACK));
      step(); idle();

      // Zero register: writes are ignored and an issue is always accepted.
      bus.WR_EN = 1'b1; bus.WR_SEL = 3'd0; bus.WR_DATA = 16'hBEEF;
      step(); idle();
      bus.RA_SEL = 3'd0; bus.ISSUE_EN = 1'b1; bus.ISSUE_SEL = 3'd0;
      sb_push("r0_data", 32'h0);
      sb_push("r0_rdy", 32'h1);
      sb_push("r0_ack", 32'h1);
      @(negedge CLK); sb_pop(32'(bus.RA_DATA)); sb_pop(32'(bus.RA_READY));
      sb_pop(32'(bus.ISSUE_ACK));
      step();
      sb_push("r0_rdy_after_issue", 32'h1);
      sb_push("r0_ack_again", 32'h1);
      @(negedge CLK); sb_pop(32'(bus.RA_READY)); sb_pop(32'(bus.ISSUE_ACK));
      step(); idle();

      // Reset during operation. Reservations are cleared and the in-flight
      // writeback is dropped.
      bus.ISSUE_EN = 1'b1; bus.ISSUE_SEL = 3'd1; step();
      bus.ISSUE_SEL = 3'd6; step(); idle();
      bus.RA_SEL = 3'd1; bus.RB_SEL = 3'd6;
      sb_push("mid_r1_pend", 32'h0);
      sb_push("mid_r6_pend", 32'h0);
      @(negedge CLK); sb_pop(32'(bus.RA_READY)); sb_pop(32'(bus.RB_READY));
      step();
      RST = 1'b1; bus.WR_EN = 1'b1; bus.WR_SEL = 3'd1; bus.WR_DATA = 16'h7777;
      step(); RST = 1'b0; idle();
      sb_push("mid_r1_rdy", 32'h1);
      sb_push("mid_r6_rdy", 32'h1);
      sb_push("mid_r1_dropped_wr", 32'h0);
      @(negedge CLK); sb_pop(32'(bus.RA_READY)); sb_pop(32'(bus.RB_READY));
      sb_pop(32'(bus.RA_DATA));
      bus.ISSUE_EN = 1'b1; bus.ISSUE_SEL = 3'd1;
      sb_push("mid_r1_reissue_ack", 32'h1);
      #1; sb_pop(32'(bus.ISSUE_ACK));
      step(); idle();

      // Random traffic, checked against the reference model. State at this
      // point: all registers 0, R1 pending.
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_pend = 8'b0000_0010;
      for (int n = 0; n < 40; n++) begin
         logic        ack_e;
         logic [2:0]  wsel;
         wsel = 3'($urandom_range(0, 7));
         bus.WR_EN     = 1'($urandom_range(0, 1));
         bus.WR_SEL    = wsel;
         bus.WR_DATA   = 16'($urandom);
         bus.ISSUE_EN  = 1'($urandom_range(0, 1));
         bus.ISSUE_SEL = ($urandom_range(0, 3) == 0) ? wsel : 3'($urandom_range(0, 7));
         bus.RA_SEL    = 3'($urandom_range(0, 7));
         bus.RB_SEL    = ($urandom_range(0, 3) == 0) ? wsel : 3'($urandom_range(0, 7));
         ack_e = bus.ISSUE_EN && (!m_pend[bus.ISSUE_SEL] ||
                                  (bus.WR_EN && bus.WR_SEL == bus.ISSUE_SEL));
         sb_push($sformatf("rnd%0d_ack", n), 32'(ack_e));
         for (int p = 0; p < 2; p++) begin
            logic [2:0]  s;
            logic [15:0] d;
            logic        r;
            s = (p == 0) ? bus.RA_SEL : bus.RB_SEL;
            d = m_regs[s];
            r = !m_pend[s];
            if (BYP && bus.WR_EN && bus.WR_SEL == s) begin d = bus.WR_DATA; r = 1'b1; end
            if (s == 3'd0) begin d = '0; r = 1'b1; end
            sb_push($sformatf("rnd%0d_%s_data", n, p == 0 ? "a" : "b"), 32'(d));
            sb_push($sformatf("rnd%0d_%s_rdy", n, p == 0 ? "a" : "b"), 32'(r));
         end
         @(negedge CLK);
         sb_pop(32'(bus.ISSUE_ACK));
         sb_pop(32'(bus.RA_DATA)); sb_pop(32'(bus.RA_READY));
         sb_pop(32'(bus.RB_DATA)); sb_pop(32'(bus.RB_READY));
         if (bus.WR_EN && bus.WR_SEL != 3'd0) begin
            m_regs[bus.WR_SEL] = bus.WR_DATA;
            m_pend[bus.WR_SEL] = 1'b0;
         end
         if (ack_e && bus.ISSUE_SEL != 3'd0) m_pend[bus.ISSUE_SEL] = 1'b1;
         step();
      end
      idle();

      chk("sb_leftover", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/reg_file_8x16.md
# reg_file_8x16

Eight-entry, 16-bit general-purpose register file with two combinational read ports, one synchronous write port and a per-register pending scoreboard. It sits directly upstream of the operand-select datapath: each read port drives its eight register outputs into a MUX_16_8 to form ALU operands A and B. The scoreboard lets issue logic reserve a destination register and stall readers until writeback.

## Interface
Parameters:
- WIDTH, 16, register data width.
- ZERO_REG, 1, when 1, R0 reads as 0, ignores writes and is never pending.

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- RA_SEL  input  3  read port A register index.
- RB_SEL  input  3  read port B register index.
- RA_DATA  output  WIDTH  port A read data.
- RB_DATA  output  WIDTH  port B read data.
- RA_READY  output  1  port A register not pending.
- RB_READY  output  1  port B register not pending.
- WR_EN  input  1  writeback strobe.
- WR_SEL  input  3  writeback register index.
- WR_DATA  input  WIDTH  writeback data.
- ISSUE_EN  input  1  request to reserve a destination register.
- ISSUE_SEL  input  3  destination register to reserve.
- ISSUE_ACK  output  1  reservation accepted this cycle.

## Operation
- State: REG[0..7] (WIDTH bits each), PEND[0..7] (1 bit each).
- Write: at the rising edge with WR_EN=1, REG[WR_SEL] <= WR_DATA and PEND[WR_SEL] <= 0. Writes to non-pending registers are legal.
- Issue: ISSUE_ACK = ISSUE_EN & (~PEND[ISSUE_SEL] | (WR_EN & WR_SEL==ISSUE_SEL)). On ACK, PEND[ISSUE_SEL] <= 1 at the edge. An issue to an already pending register without a same-cycle writeback is refused (ACK=0, no state change). The requester holds ISSUE_EN until ACK.
- Simultaneous write and ACKed issue to the same index: REG takes WR_DATA and PEND ends at 1 (set wins).
- Read: RA_DATA = REG[RA_SEL] via MUX_16_8. RA_READY = ~PEND[RA_SEL]. Port B is identical.
- ZERO_REG=1: index 0 reads 0 with READY=1. WR_EN to 0 is ignored. ISSUE_SEL=0 is always ACKed and sets nothing.
- Both read ports may select the same register, and may select the register being written.

## Timing
- Reads are combinational, zero-cycle latency from SEL to DATA/READY.
- A write becomes visible on the read ports in the cycle after the edge (one-cycle write-to-read latency) unless RF_BYPASS_EN is defined.
- ISSUE_ACK is combinational. PEND updates at the edge, so a reader stalls from the next cycle.
- Reset: at an edge with RST=1, all REG <= 0 and all PEND <= 0. During reset, WR_EN and ISSUE_EN are ignored.
- Reset values seen after the reset edge: RA_DATA=RB_DATA=0, RA_READY=RB_READY=1, ISSUE_ACK follows ISSUE_EN.
- Reset asserted mid-operation clears all reservations, and any in-flight writeback of that cycle is dropped.

## Configuration
- RF_BYPASS_EN defined: a read port whose SEL equals WR_SEL while WR_EN=1 returns WR_DATA and READY=1 in the same cycle. Excluded for R0 when ZERO_REG=1.
- RF_BYPASS_EN undefined: the read port returns the old REG value with READY=~PEND until the edge, so there is a one-cycle bubble after writeback.

## Structure
- Shared package rf_pkg holds RF_WIDTH=16, RF_ADDR_W=3 and RF_NUM_REGS=8. These constants are shared with the operand-select and writeback stages.
- Sub-module rf_read_port, instantiated twice:
  - MUX_16_8 over REG[0..7] with the three SEL bits as S0..S2.
  - Ready selection from PEND.
  - Optional bypass compare/override.
- Top-level holds the REG/PEND flops, write decode and issue/ACK logic.

## Test plan
- Reset: RST=1 for 1 edge with WR_EN=1, WR_SEL=3, WR_DATA=16'hFFFF -> REG[3]=0 and every read is 0 with READY=1.
- Write then read: WR_EN=1, WR_SEL=5, WR_DATA=16'hA5C3, then RA_SEL=5 next cycle -> RA_DATA=16'hA5C3. Same cycle gives old value 0 without bypass, and 16'hA5C3 with RF_BYPASS_EN.
- Scoreboard: issue R2 (ACK=1) -> RB_SEL=2 gives RB_READY=0. A second issue to R2 gives ACK=0. Writeback R2=16'h0042 -> READY=1 next cycle and DATA=16'h0042.
- Simultaneous: R4 pending, WR_EN to R4 with 16'h1234 plus ISSUE_EN R4 in the same cycle -> ACK=1, REG[4]=16'h1234 and PEND[4]=1 after the edge.
- Zero register: WR_EN to R0 with 16'hBEEF, then issue R0 -> R0 reads 0, READY=1 and ACK=1.
- Reset mid-operation: pend R1 and R6, then RST=1 -> both READY=1 after the edge and a subsequent issue to R1 is ACKed.
